// File: rtl/fp16_mul_sched.sv
// Arbiter, tag pipe and credit-protected response FIFO around a shared fp16 mul_pipe.
// Define MUL_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module fp16_mul_sched #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 4,
    parameter int DEPTH   = 8,
    parameter int ID_W    = 3
) (
    input  logic                 clk_59,
    input  logic                 reset_59,
    input  logic                 en,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*16-1:0]   req_b,
    output logic [15:0]          mul_a,
    output logic [15:0]          mul_b,
    input  logic [15:0]          mul_res,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [15:0]          rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 idle
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + MUL_LAT + 2) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state, stateNxt;
    logic [MUL_LAT:0]    tagV;
    logic [ID_W-1:0]     tagId [MUL_LAT+1];
    logic [15:0]         memData [DEPTH];
    logic [ID_W-1:0]     memId [DEPTH];
    logic [PW-1:0]       wrPtr, rdPtr;
    logic [CW-1:0]       count, inflight;
    logic [ID_W-1:0]     winner;
    logic                canIssue, issue, push, pop;

    function automatic logic [PW-1:0] incPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int k = 0; k <= MUL_LAT; k++)
            inflight = inflight + CW'(tagV[k]);
    end

    // Credits count both buffered and in-flight results, so a push always has room.
    assign canIssue  = (count + inflight) < CW'(DEPTH);
    assign push      = tagV[MUL_LAT];
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_data  = rsp_valid ? memData[rdPtr] : '0;
    assign rsp_id    = rsp_valid ? memId[rdPtr] : '0;
    assign idle      = (state == IDLE);

`ifdef MUL_SCHED_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req_valid[k]) winner = ID_W'(k);
    end
`else
    localparam logic [ID_W:0] NR = (ID_W+1)'(NREQ);

    logic [ID_W-1:0]     rrPtr, off;
    logic [2*NREQ-1:0]   dbl;
    logic [NREQ-1:0]     rot;
    logic [ID_W:0]       sum, rrNxt;

    // Rotate so the search starts at rrPtr, then map the offset back.
    always_comb begin
        dbl = {req_valid, req_valid} >> rrPtr;
        rot = dbl[NREQ-1:0];
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (rot[k]) off = ID_W'(k);
        sum = {1'b0, rrPtr} + {1'b0, off};
        if (sum >= NR) sum = sum - NR;
        winner = sum[ID_W-1:0];
        rrNxt = {1'b0, winner} + 1'b1;
        if (rrNxt >= NR) rrNxt = '0;
    end

    always_ff @(posedge clk_59 or negedge reset_59) begin
        if (!reset_59) rrPtr <= '0;
        else if (issue) rrPtr <= rrNxt[ID_W-1:0];
    end
`endif

    always_comb begin
        issue     = 1'b0;
        req_ready = '0;
        if (state == RUN && en && canIssue && |req_valid) begin
            issue     = 1'b1;
            req_ready = NREQ'(1) << winner;
        end
    end

    always_ff @(posedge clk_59 or negedge reset_59) begin
        if (!reset_59) begin
            mul_a <= '0;
            mul_b <= '0;
            tagV  <= '0;
            for (int k = 0; k <= MUL_LAT; k++) tagId[k] <= '0;
        end else begin
            mul_a    <= issue ? req_a[16*winner +: 16] : '0;
            mul_b    <= issue ? req_b[16*winner +: 16] : '0;
            tagV     <= {tagV[MUL_LAT-1:0], issue};
            tagId[0] <= winner;
            for (int k = 1; k <= MUL_LAT; k++) tagId[k] <= tagId[k-1];
        end
    end

    always_ff @(posedge clk_59 or negedge reset_59) begin
        if (!reset_59) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                memData[k] <= '0;
                memId[k]   <= '0;
            end
        end else begin
            if (push) begin
                memData[wrPtr] <= mul_res;
                memId[wrPtr]   <= tagId[MUL_LAT];
                wrPtr          <= incPtr(wrPtr);
            end
            if (pop) rdPtr <= incPtr(rdPtr);
            unique case (1'b1)
                push && !pop: count <= count + 1'b1;
                pop && !push: count <= count - 1'b1;
                default:      count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_59 or negedge reset_59) begin
        if (!reset_59) state <= IDLE;
        else           state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        unique case (state)
            IDLE:  if (en) stateNxt = RUN;
            RUN:   if (!en) stateNxt = DRAIN;
            DRAIN: begin
                if (en)
                    stateNxt = RUN;
                else if (inflight == '0 && count == '0)
                    stateNxt = IDLE;
            end
            default: stateNxt = IDLE;
        endcase
    end

endmodule
